// File: rtl/uart_rx_pkg.sv
// Shared UART constants and receiver state encoding (also used by the TX path).
package uart_rx_pkg;
  localparam logic [12:0] BPS_T_9600    = 13'd5208;  // 50 MHz / 9600
  localparam logic [12:0] BPS_HALF_9600 = 13'd2604;  // bit centre
  localparam int          DATA_BITS     = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;
endpackage

// File: rtl/rx_bps_module.sv
// Receive baud generator: counts bit periods while a frame is active and
// strobes BPS_CLK once per bit at its centre. Mirror of the TX bps generator.
module rx_bps_module
  import uart_rx_pkg::*;
#(
  parameter logic [12:0] BPS_T    = BPS_T_9600,
  parameter logic [12:0] BPS_HALF = BPS_HALF_9600
)(
  input  logic CLK,
  input  logic Rstn,
  input  logic Count_Sig,
  output logic BPS_CLK
);
  logic [12:0] cnt_q, cnt_d;

  // Free-run over one bit period while counting, parked at 0 otherwise.
  always_comb begin
    cnt_d = 13'd0;
    if (Count_Sig) begin
      if (cnt_q == BPS_T - 13'd1) cnt_d = 13'd0;
      else                        cnt_d = cnt_q + 13'd1;
    end
  end

  // Counter register.
  always_ff @(posedge CLK or negedge Rstn) begin
    if (!Rstn) cnt_q <= 13'd0;
    else       cnt_q <= cnt_d;
  end

  assign BPS_CLK = (cnt_q == BPS_HALF);
endmodule

// File: rtl/uart_rx_module.sv
// UART 8N1 receiver with centre sampling.
// Optional macro UART_RX_PARITY_EN adds a parity bit (PARITY_ODD selects sense).
module uart_rx_module
  import uart_rx_pkg::*;
#(
  parameter logic [12:0] BPS_T    = BPS_T_9600,
  parameter logic [12:0] BPS_HALF = BPS_HALF_9600
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
)(
  input  logic       CLK,
  input  logic       Rstn,
  input  logic       RX_Pin_In,
  input  logic       RX_En,
  output logic [7:0] RX_Data,
  output logic       RX_Done_Sig,
  output logic       RX_Err_Sig,
  output logic       RX_Busy
);
  logic       sync1_q, sync2_q, sync3_q;
  logic       rx_s, h2l, count_sig, bps_clk, par_ok;
  rx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d, data_q, data_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       done_q, done_d, err_q, err_d;
`ifdef UART_RX_PARITY_EN
  logic       par_q, par_d;
`endif

  // Two-flop synchronizer plus a history flop for start-edge detection.
  always_ff @(posedge CLK or negedge Rstn) begin
    if (!Rstn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= RX_Pin_In;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rx_s      = sync2_q;
  assign h2l       = sync3_q & ~sync2_q;
  assign count_sig = (state_q != IDLE);

  rx_bps_module #(.BPS_T(BPS_T), .BPS_HALF(BPS_HALF)) u_bps (
    .CLK      (CLK),
    .Rstn     (Rstn),
    .Count_Sig(count_sig),
    .BPS_CLK  (bps_clk)
  );

`ifdef UART_RX_PARITY_EN
  assign par_ok = (((^shift_q) ^ par_q) == PARITY_ODD);
`else
  assign par_ok = 1'b1;
`endif

  // Frame FSM: next state, shift register and output pulses.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      IDLE: if (h2l && RX_En) state_d = START;
      START: if (bps_clk) begin
        // A line back high at the start-bit centre was a glitch.
        if (!rx_s) begin
          state_d   = DATA;
          bit_cnt_d = 4'd0;
        end else begin
          state_d   = IDLE;
        end
      end
      DATA: if (bps_clk) begin
        shift_d   = {rx_s, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (bps_clk) begin
        par_d   = rx_s;
        state_d = STOP;
      end
`endif
      STOP: if (bps_clk) begin
        // Leave at mid stop bit so a following start edge is not missed.
        state_d = IDLE;
        if (rx_s && par_ok) begin
          data_d = shift_q;
          done_d = 1'b1;
        end else begin
          err_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge CLK or negedge Rstn) begin
    if (!Rstn) begin
      state_q   <= IDLE;
      shift_q   <= 8'd0;
      bit_cnt_q <= 4'd0;
      data_q    <= 8'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign RX_Data     = data_q;
  assign RX_Done_Sig = done_q;
  assign RX_Err_Sig  = err_q;
  assign RX_Busy     = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_module.sv
// Directed bench for uart_rx_module, run at a reduced bit period.
module tb_uart_rx_module;
  localparam int BT = 64;
  localparam int BH = 32;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Pin fall to Done, measured in clock cycles.
  localparam int LAT = 3 + (NBITS - 1) * BT + BH + 2;

  logic       CLK = 1'b0;
  logic       Rstn = 1'b0;
  logic       RX_Pin_In = 1'b1;
  logic       RX_En = 1'b1;
  logic [7:0] RX_Data;
  logic       RX_Done_Sig, RX_Err_Sig, RX_Busy;

  int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, last_done_cyc = 0;
  int passes = 0, total = 0, fails = 0;
  int t0, lat;
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  uart_rx_module #(.BPS_T(13'(BT)), .BPS_HALF(13'(BH))) dut (
    .CLK        (CLK),
    .Rstn       (Rstn),
    .RX_Pin_In  (RX_Pin_In),
    .RX_En      (RX_En),
    .RX_Data    (RX_Data),
    .RX_Done_Sig(RX_Done_Sig),
    .RX_Err_Sig (RX_Err_Sig),
    .RX_Busy    (RX_Busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (RX_Done_Sig) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (RX_Err_Sig) err_cnt++;
    if (RX_Done_Sig && RX_Err_Sig) both_cnt++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_bit(input logic b);
    RX_Pin_In = b;
    wait_cyc(BT);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, output int ts);
    ts = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`endif
    send_bit(stop_b);
  endtask

  task automatic check_lat(input string tag);
    lat = last_done_cyc - t0;
    check($sformatf("%s(lat=%0d)", tag, lat), int'(lat >= LAT - 4 && lat <= LAT + 4), 1);
  endtask

  initial begin
    // Reset state
    wait_cyc(5);
    check("rst_data", RX_Data, 0);
    check("rst_done", RX_Done_Sig, 0);
    check("rst_err",  RX_Err_Sig, 0);
    check("rst_busy", RX_Busy, 0);
    Rstn = 1'b1;
    wait_cyc(5);

    // Single frame 0x55
    send_frame(8'h55, 1'b1, t0);
    check("f55_data", RX_Data, 8'h55);
    check("f55_done", done_cnt, 1);
    check("f55_err",  err_cnt, 0);
    check_lat("f55_lat");
    check("f55_busy", RX_Busy, 0);

    // Back-to-back 0xA3, 0x0F
    send_frame(8'hA3, 1'b1, t0);
    check("fa3_data", RX_Data, 8'hA3);
    check_lat("fa3_lat");
    send_frame(8'h0F, 1'b1, t0);
    check("f0f_data", RX_Data, 8'h0F);
    check("b2b_done", done_cnt, 3);
    check("b2b_err",  err_cnt, 0);

    // Short glitch aborts in START
    RX_Pin_In = 1'b0;
    wait_cyc(16);
    RX_Pin_In = 1'b1;
    wait_cyc(2 * BT);
    check("gl_done", done_cnt, 3);
    check("gl_err",  err_cnt, 0);
    check("gl_data", RX_Data, 8'h0F);
    check("gl_busy", RX_Busy, 0);

    // Framing error: stop bit low
    send_frame(8'hC6, 1'b0, t0);
    RX_Pin_In = 1'b1;
    wait_cyc(BT);
    check("fe_err",  err_cnt, 1);
    check("fe_done", done_cnt, 3);
    check("fe_data", RX_Data, 8'h0F);

    // Disabled receiver ignores a frame
    RX_En = 1'b0;
    send_frame(8'h99, 1'b1, t0);
    wait_cyc(BT);
    check("en0_done", done_cnt, 3);
    check("en0_data", RX_Data, 8'h0F);
    RX_En = 1'b1;

    // Dropping RX_En mid-frame does not abort it
    fork
      send_frame(8'h5A, 1'b1, t0);
      begin wait_cyc(3 * BT); RX_En = 1'b0; end
    join
    check("enmid_data", RX_Data, 8'h5A);
    check("enmid_done", done_cnt, 4);
    RX_En = 1'b1;
    wait_cyc(BT);

    // Reset during data bit 4 of 0x3C, held until the line is idle
    fork
      send_frame(8'h3C, 1'b1, t0);
      begin
        wait_cyc(5 * BT + BT / 2);
        Rstn = 1'b0;
        wait_cyc(2);
        check("rmid_busy", RX_Busy, 0);
      end
    join
    wait_cyc(BT);
    Rstn = 1'b1;
    wait_cyc(5);
    check("rmid_done", done_cnt, 4);
    check("rmid_err",  err_cnt, 1);
    check("rmid_data", RX_Data, 0);
    send_frame(8'h81, 1'b1, t0);
    check("f81_data", RX_Data, 8'h81);
    check("f81_done", done_cnt, 5);
    check_lat("f81_lat");

    // Break: line held low gives exactly one error
    RX_Pin_In = 1'b0;
    wait_cyc(3 * NBITS * BT);
    check("brk_err",  err_cnt, 2);
    check("brk_done", done_cnt, 5);
    check("brk_busy", RX_Busy, 0);
    RX_Pin_In = 1'b1;
    wait_cyc(2 * BT);
    check("brk_data", RX_Data, 8'h81);

`ifdef UART_RX_PARITY_EN
    // Even parity: correct then wrong parity bit on 0x07
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1, t0);
    check("par_ok_data", RX_Data, 8'h07);
    check("par_ok_done", done_cnt, 6);
    check_lat("par_ok_lat");
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, t0);
    check("par_bad_err",  err_cnt, 3);
    check("par_bad_done", done_cnt, 6);
    par_flip = 1'b0;
`endif

    check("never_both", both_cnt, 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
